// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types and output-decode constants for the stopwatch control path.
//   sw_state_t is the mode encoding seen on stopwatch_ctrl.o_state and is
//   reused by the display path and the benches.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } sw_state_t;

  // Per-state output decode, bit index = state encoding.
  // Counting runs in RUN and LAP; the display is frozen only in LAP.
  localparam logic [3:0] COUNT_EN_MASK  = 4'b0110;
  localparam logic [3:0] DISP_HOLD_MASK = 4'b0100;

  function automatic logic state_count_en(input sw_state_t s);
    return COUNT_EN_MASK[s];
  endfunction

  function automatic logic state_disp_hold(input sw_state_t s);
    return DISP_HOLD_MASK[s];
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce
//   One push-button conditioning chain: 2-flop synchronizer, counter-based
//   debouncer and rising-edge detector.
//   i_sclk     system clock
//   i_reset_n  asynchronous active-low reset
//   i_btn      raw button level, asynchronous to i_sclk
//   o_level    debounced button level
//   o_press    one-cycle pulse on each accepted rising edge of o_level
//   The debounced level flips only after the synchronized level has
//   disagreed with it for DEBOUNCE_CYCLES consecutive cycles (>= 2).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic i_sclk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync_q2 == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync_q2;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level_q;
    end
  end

  // Combinational from registered levels so the FSM can react on the edge
  // right after the debounced level rises.
  assign o_level = level_q;
  assign o_press = level_q & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Mode sequencer for the stopwatch datapath.
//   i_sclk       system clock
//   i_reset_n    asynchronous active-low reset
//   i_btn_ss     raw start/stop button (active high, asynchronous)
//   i_btn_lr     raw lap/reset button (active high, asynchronous)
//   o_count_en   time-counter enable (RUN, LAP)
//   o_count_clr  one-cycle clear pulse after lr is taken in IDLE or STOP
//   o_disp_hold  freezes the display latch (LAP)
//   o_state      current mode, sw_state_t encoding
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_btn_ss,
  input  logic       i_btn_lr,
  output logic       o_count_en,
  output logic       o_count_clr,
  output logic       o_disp_hold,
  output logic [1:0] o_state
);

  logic      ss_level;
  logic      ss_press;
  logic      lr_level;
  logic      lr_press;
  sw_state_t state_q;
  sw_state_t state_d;
  logic      clr_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_ss (
    .i_sclk    (i_sclk),
    .i_reset_n (i_reset_n),
    .i_btn     (i_btn_ss),
    .o_level   (ss_level),
    .o_press   (ss_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_lr (
    .i_sclk    (i_sclk),
    .i_reset_n (i_reset_n),
    .i_btn     (i_btn_lr),
    .o_level   (lr_level),
    .o_press   (lr_press)
  );

  // A press pulse can only appear while its debounced level is high.
  a_ss_press_level : assert property (@(posedge i_sclk) disable iff (!i_reset_n)
    ss_press |-> ss_level);
  a_lr_press_level : assert property (@(posedge i_sclk) disable iff (!i_reset_n)
    lr_press |-> lr_level);

  // Start/stop is tested first everywhere, so a same-cycle lr press is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_press)      state_d = ST_RUN;
        else if (lr_press) clr_d   = 1'b1;
      end
      ST_RUN: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lr_press) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lr_press) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_press) begin
          state_d = ST_RUN;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from next-state so they move on the same edge as state.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      o_count_en  <= 1'b0;
      o_disp_hold <= 1'b0;
      o_count_clr <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_count_en  <= state_count_en(state_d);
      o_disp_hold <= state_disp_hold(state_d);
      o_count_clr <= clr_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Scenario tasks with inline checks against constants and against a
//   behavioural model of the stopwatch (button history, run-length debounce,
//   mode table).
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DEB = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .i_sclk      (clk),
    .i_reset_n   (rst_n),
    .i_btn_ss    (btn_ss),
    .i_btn_lr    (btn_lr),
    .o_count_en  (count_en),
    .o_count_clr (count_clr),
    .o_disp_hold (disp_hold),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Bit 0 = ss, bit 1 = lr throughout.
  sw_state_t  m_st   = ST_IDLE;
  logic       m_en   = 1'b0;
  logic       m_clr  = 1'b0;
  logic       m_hold = 1'b0;
  logic [1:0] m_hist[$];        // raw samples taken at previous edges
  logic [1:0] m_deb  = 2'b00;   // accepted button levels
  logic [1:0] m_p    = 2'b00;   // press accepted at the previous edge
  int         m_run[2];         // consecutive disagreeing cycles

  task automatic model_reset();
    m_st = ST_IDLE; m_en = 1'b0; m_clr = 1'b0; m_hold = 1'b0;
    m_hist.delete();
    m_deb = 2'b00; m_p = 2'b00; m_run[0] = 0; m_run[1] = 0;
  endtask

  task automatic model_edge();
    sw_state_t nst;
    logic      clr;
    logic      seen;
    nst = m_st;
    clr = 1'b0;
    if (m_p[0]) begin
      nst = (m_st == ST_RUN || m_st == ST_LAP) ? ST_STOP : ST_RUN;
    end else if (m_p[1]) begin
      if (m_st == ST_RUN)      nst = ST_LAP;
      else if (m_st == ST_LAP) nst = ST_RUN;
      else begin nst = ST_IDLE; clr = 1'b1; end
    end
    m_st   = nst;
    m_clr  = clr;
    m_en   = (nst == ST_RUN) || (nst == ST_LAP);
    m_hold = (nst == ST_LAP);
    // The level seen by the debouncer is the raw sample from two edges back.
    for (int b = 0; b < 2; b++) begin
      seen   = (m_hist.size() == 2) ? m_hist[0][b] : 1'b0;
      m_p[b] = 1'b0;
      if (seen !== m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DEB)) begin
          m_deb[b] = seen;
          m_run[b] = 0;
          m_p[b]   = seen;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_hist.push_back({btn_lr, btn_ss});
    if (m_hist.size() > 2) m_hist.delete(0);
  endtask

  initial begin
    m_run[0] = 0;
    m_run[1] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic press_btn(input int which, input int hi, input int lo);
    if (which == 0) btn_ss = 1'b1;
    else            btn_lr = 1'b1;
    repeat (hi) @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  function automatic int unsigned off_edge_delay();
    int unsigned d;
    d = $urandom_range(1, 8);
    if (d == 5) d = 6;
    return d;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int unsigned d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({state, count_en, count_clr, disp_hold} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_values got=%b want=%b", {state, count_en, count_clr, disp_hold}, 5'b00000);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      total++;
      if ({state, count_en, count_clr, disp_hold} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", j, {state, count_en, count_clr, disp_hold}, 5'b00000);
      end
    end
    d = off_edge_delay();
    #(d);
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, count_en, count_clr, disp_hold} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", {state, count_en, count_clr, disp_hold}, 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 5; r++) begin
      btn_ss = 1'b1;
      repeat (3) @(negedge clk);
      btn_ss = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    total++;
    if (state !== 2'b00 || {state, count_en, count_clr, disp_hold} !== {m_st, m_en, m_clr, m_hold}) begin
      bad++;
      $display("FAIL glitch state got=%b want=00 model=%b", state, m_st);
    end
  endtask

  task automatic test_start();
    btn_ss = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      total++;
      if (state !== ((j >= 7) ? 2'b01 : 2'b00) || count_en !== (j >= 7)) begin
        bad++;
        $display("FAIL start_latency edge=%0d got=%b/%b want=%b/%b", j, state, count_en,
                 (j >= 7) ? 2'b01 : 2'b00, (j >= 7));
      end
    end
    btn_ss = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      total++;
      if (state !== 2'b01 || count_en !== 1'b1 || count_clr !== 1'b0) begin
        bad++;
        $display("FAIL start_hold cyc=%0d got=%b/%b/%b want=01/1/0", j, state, count_en, count_clr);
      end
    end
  endtask

  task automatic test_lap();
    press_btn(1, $urandom_range(4, 8), 12);
    total++;
    if ({state, count_en, disp_hold, count_clr} !== 5'b10110) begin
      bad++;
      $display("FAIL lap_enter got=%b want=%b", {state, count_en, disp_hold, count_clr}, 5'b10110);
    end
    press_btn(1, $urandom_range(4, 8), 12);
    total++;
    if ({state, count_en, disp_hold, count_clr} !== 5'b01100) begin
      bad++;
      $display("FAIL lap_exit got=%b want=%b", {state, count_en, disp_hold, count_clr}, 5'b01100);
    end
  endtask

  task automatic test_stop_clear();
    int clr_cnt;
    int clr_at;
    press_btn(0, $urandom_range(4, 8), 12);
    total++;
    if ({state, count_en, disp_hold} !== 4'b1100) begin
      bad++;
      $display("FAIL stop_enter got=%b want=%b", {state, count_en, disp_hold}, 4'b1100);
    end
    clr_cnt = 0;
    clr_at  = -1;
    btn_lr  = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (count_clr === 1'b1) begin clr_cnt++; clr_at = j; end
      total++;
      if ({state, count_en, count_clr, disp_hold} !== {m_st, m_en, m_clr, m_hold}) begin
        bad++;
        $display("FAIL clear_model edge=%0d got=%b want=%b", j, {state, count_en, count_clr, disp_hold},
                 {m_st, m_en, m_clr, m_hold});
      end
    end
    total++;
    if (clr_cnt != 1 || clr_at != 7 || state !== 2'b00) begin
      bad++;
      $display("FAIL clear_pulse got=cnt%0d@%0d state=%b want=cnt1@7 state=00", clr_cnt, clr_at, state);
    end
    btn_lr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_held_reset();
    rst_n  = 1'b0;
    btn_ss = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      total++;
      if (state !== ((j >= 7) ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL held_reset edge=%0d got=%b want=%b", j, state, (j >= 7) ? 2'b01 : 2'b00);
      end
    end
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    // Back to IDLE for the next scenario.
    press_btn(0, 5, 12);
    press_btn(1, 5, 12);
  endtask

  task automatic test_simultaneous_reset();
    int          n;
    int unsigned d;
    total++;
    if (state !== 2'b00) begin
      bad++;
      $display("FAIL simul_precond got=%b want=00", state);
    end
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 8) begin btn_ss = 1'b0; btn_lr = 1'b0; end
      total++;
      if (count_clr !== 1'b0 || {state, count_en, count_clr, disp_hold} !== {m_st, m_en, m_clr, m_hold}) begin
        bad++;
        $display("FAIL simul cyc=%0d got=%b want=%b clr0", j, {state, count_en, count_clr, disp_hold},
                 {m_st, m_en, m_clr, m_hold});
      end
    end
    total++;
    if (state !== 2'b01) begin
      bad++;
      $display("FAIL simul_state got=%b want=01", state);
    end
    // Bounce ss with runs too short to be accepted.
    n = 0;
    while (n < 16) begin
      btn_ss = ~btn_ss;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        @(negedge clk);
        n++;
        total++;
        if (state !== 2'b01) begin
          bad++;
          $display("FAIL bounce_run cyc=%0d got=%b want=01", n, state);
        end
      end
    end
    btn_ss = ~btn_ss;
    d = off_edge_delay();
    #(d);
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, count_en, count_clr, disp_hold} !== 5'b00000) begin
      bad++;
      $display("FAIL midrun_reset got=%b want=%b", {state, count_en, count_clr, disp_hold}, 5'b00000);
    end
    @(negedge clk);
    btn_ss = 1'b0;
    rst_n  = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      total++;
      if ({state, count_en, count_clr, disp_hold} !== 5'b00000) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got=%b want=%b", j, {state, count_en, count_clr, disp_hold}, 5'b00000);
      end
    end
  endtask

  task automatic test_random();
    int left_ss;
    int left_lr;
    left_ss = 0;
    left_lr = 0;
    for (int j = 0; j < 1500; j++) begin
      if (left_ss == 0) begin btn_ss = 1'($urandom_range(0, 1)); left_ss = $urandom_range(1, 12); end
      if (left_lr == 0) begin btn_lr = 1'($urandom_range(0, 1)); left_lr = $urandom_range(1, 12); end
      left_ss--;
      left_lr--;
      if (j == 700) rst_n = 1'b0;
      if (j == 703) rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({state, count_en, count_clr, disp_hold} !== {m_st, m_en, m_clr, m_hold}) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", j, {state, count_en, count_clr, disp_hold},
                 {m_st, m_en, m_clr, m_hold});
      end
    end
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_start();
    test_lap();
    test_stop_clear();
    test_held_reset();
    test_simultaneous_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
